// File: rtl/bike_sweep_scheduler.sv
// rtl/bike_sweep_scheduler.sv - round-robin owner of one shared 0..MAX_ADDR address sweep
// Optional abort port and early sweep termination: define BIKE_SWEEP_ABORT_EN.
module bike_sweep_scheduler #(
    parameter int NUM_REQ   = 3,
    parameter int ADDR_SIZE = 5,
    parameter int MAX_ADDR  = 20
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [NUM_REQ-1:0]   req_i,
`ifdef BIKE_SWEEP_ABORT_EN
    input  logic [NUM_REQ-1:0]   abort_i,
`endif
    output logic [NUM_REQ-1:0]   grant_o,
    output logic [ADDR_SIZE-1:0] addr_o,
    output logic                 addr_valid_o,
    input  logic                 addr_ready_i,
    output logic [NUM_REQ-1:0]   done_o,
    output logic                 busy_o
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MAX_ADDR);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic                 addr_valid_q, addr_valid_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]     owner_q, owner_d;

    logic                 found;
    logic [PTR_W-1:0]     winner;
    logic [PTR_W:0]       sum;
    logic [2*NUM_REQ-1:0] req_rot;
    logic                 abort_hit;
    logic                 last_xfer;
    logic [PTR_W-1:0]     ptr_next;

`ifdef BIKE_SWEEP_ABORT_EN
    assign abort_hit = |(abort_i & grant_q);
`else
    assign abort_hit = 1'b0;
`endif

    // Rotate requests so bit 0 is the requester at rr_ptr; the lowest set bit wins.
    assign req_rot = {req_i, req_i} >> rr_ptr_q;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        sum    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
                if (sum >= (PTR_W+1)'(NUM_REQ)) begin
                    sum = sum - (PTR_W+1)'(NUM_REQ);
                end
                winner = sum[PTR_W-1:0];
            end
        end
    end

    assign last_xfer = addr_valid_q && addr_ready_i && (addr_q == LAST_ADDR);
    assign ptr_next  = (owner_q == PTR_W'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        addr_valid_d = addr_valid_q;
        done_d       = '0;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d      = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
                    owner_d      = winner;
                    addr_d       = '0;
                    addr_valid_d = 1'b1;
                    state_d      = S_SWEEP;
                end
            end
            S_SWEEP: begin
                // Abort and the final transfer both close the sweep the same way.
                if (abort_hit || last_xfer) begin
                    addr_d       = '0;
                    addr_valid_d = 1'b0;
                    done_d       = grant_q;
                    grant_d      = '0;
                    rr_ptr_d     = ptr_next;
                    state_d      = S_DONE;
                end else if (addr_valid_q && addr_ready_i) begin
                    addr_d = addr_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            addr_q       <= '0;
            addr_valid_q <= 1'b0;
            done_q       <= '0;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            addr_valid_q <= addr_valid_d;
            done_q       <= done_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
        end
    end

    assign grant_o      = grant_q;
    assign addr_o       = addr_q;
    assign addr_valid_o = addr_valid_q;
    assign done_o       = done_q;
    assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_bike_sweep_scheduler.sv
// tb/tb_bike_sweep_scheduler.sv - scoreboard bench for bike_sweep_scheduler
module tb_bike_sweep_scheduler;

    localparam int N    = 3;
    localparam int AW   = 5;
    localparam int MAXA = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  abort_s = '0;
    logic          ready = 1'b0;
    logic [N-1:0]  grant;
    logic [AW-1:0] addr;
    logic          addr_valid;
    logic [N-1:0]  done;
    logic          busy;

    bike_sweep_scheduler #(.NUM_REQ(N), .ADDR_SIZE(AW), .MAX_ADDR(MAXA)) dut (
        .clk_i        (clk),
        .reset_i      (rst),
        .req_i        (req),
`ifdef BIKE_SWEEP_ABORT_EN
        .abort_i      (abort_s),
`endif
        .grant_o      (grant),
        .addr_o       (addr),
        .addr_valid_o (addr_valid),
        .addr_ready_i (ready),
        .done_o       (done),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           is_done;
        logic [N-1:0] mask;
        int           a;
    } ev_t;

    ev_t exp_q[$];
    ev_t e;
    int  errors = 0;
    int  checks = 0;
    int  xfer_cnt = 0;
    bit  gap_chk = 0;
    bit  gap_seen = 0;
    int  low_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_sweep(input logic [N-1:0] m, input int last);
        ev_t x;
        for (int a = 0; a <= last; a++) begin
            x.is_done = 1'b0; x.mask = m; x.a = a;
            exp_q.push_back(x);
        end
        x.is_done = 1'b1; x.mask = m; x.a = 0;
        exp_q.push_back(x);
    endtask

    task automatic wait_done(input logic [N-1:0] m, input int budget, input string name);
        bit got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (done != '0) got = 1;
        end
        if (!got) chk({name, "_timeout"}, 0, 1);
        else begin
            chk({name, "_done"}, int'(done), int'(m));
            chk({name, "_grant_clr"}, int'(grant), 0);
            chk({name, "_valid_low"}, int'(addr_valid), 0);
        end
    endtask

    task automatic wait_addr(input int a, input int budget, input string name);
        bit got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (addr_valid && int'(addr) == a) got = 1;
        end
        if (!got) chk({name, "_addr_timeout"}, 0, 1);
    endtask

    // Monitor: every handshake and every done pulse must match the head of the queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (addr_valid && ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) chk("unexpected_xfer", int'(addr), -1);
                else begin
                    e = exp_q.pop_front();
                    chk("xfer_kind", 0, int'(e.is_done));
                    chk("xfer_grant", int'(grant), int'(e.mask));
                    chk("xfer_addr", int'(addr), e.a);
                end
            end
            if (done != '0) begin
                if (exp_q.size() == 0) chk("unexpected_done", int'(done), 0);
                else begin
                    e = exp_q.pop_front();
                    chk("done_kind", 1, int'(e.is_done));
                    chk("done_mask", int'(done), int'(e.mask));
                end
            end
            if (addr_valid) begin
                if (gap_chk && gap_seen && low_cnt > 0) chk("sweep_gap", low_cnt, 2);
                gap_seen = 1;
                low_cnt  = 0;
            end else begin
                low_cnt++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int bad;
        bit got;
        bit prev_stall;
        int prev_addr;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", int'(grant), 0);
        chk("rst_addr", int'(addr), 0);
        chk("rst_valid", int'(addr_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;

        // single requester, full-speed sweep
        push_sweep(3'b001, MAXA);
        @(posedge clk); #1 req = 3'b001; ready = 1'b1;
        @(negedge clk);
        chk("t2_grant_pre", int'(grant), 0);
        @(negedge clk);
        chk("t2_grant", int'(grant), 1);
        chk("t2_valid", int'(addr_valid), 1);
        chk("t2_addr0", int'(addr), 0);
        cyc = 0; got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            cyc++;
            if (done != '0) got = 1;
        end
        chk("t2_sweep_len", cyc, MAXA + 1);
        chk("t2_done", int'(done), 1);
        chk("t2_grant_clr", int'(grant), 0);
        @(posedge clk); #1 req = '0;
        @(negedge clk);
        @(negedge clk);
        chk("t2_idle_busy", int'(busy), 0);

        // asynchronous reset in the middle of a sweep
        push_sweep(3'b001, MAXA);
        @(posedge clk); #1 req = 3'b001;
        wait_addr(10, 40, "t1");
        #2 rst = 1'b1;
        #1;
        chk("t1_grant", int'(grant), 0);
        chk("t1_addr", int'(addr), 0);
        chk("t1_valid", int'(addr_valid), 0);
        chk("t1_done", int'(done), 0);
        chk("t1_busy", int'(busy), 0);
        exp_q.delete();
        req = '0;
        @(posedge clk); #1 rst = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy || grant != '0 || done != '0) bad++;
        end
        chk("t1_idle_after", bad, 0);

        // all three requesting: strict round robin with 2-cycle gaps
        push_sweep(3'b001, MAXA);
        push_sweep(3'b010, MAXA);
        push_sweep(3'b100, MAXA);
        push_sweep(3'b001, MAXA);
        @(posedge clk); #1 gap_chk = 1; gap_seen = 0; low_cnt = 0; req = 3'b111;
        wait_done(3'b001, 40, "t3a");
        wait_done(3'b010, 40, "t3b");
        wait_done(3'b100, 40, "t3c");
        got = 0;
        for (int i = 0; i < 5 && !got; i++) begin
            @(negedge clk);
            if (grant != '0) got = 1;
        end
        chk("t3_fourth_grant", int'(grant), 1);
        @(posedge clk); #1 req = '0;
        wait_done(3'b001, 40, "t3d");
        @(posedge clk); #1 gap_chk = 0;

        // ready toggling: address holds while stalled
        push_sweep(3'b010, MAXA);
        @(posedge clk); #1 req = 3'b010; xfer_cnt = 0; ready = 1'b1;
        got = 0; prev_stall = 0; prev_addr = 0;
        for (int i = 0; i < 80 && !got; i++) begin
            @(negedge clk);
            if (prev_stall) chk("t4_hold", int'(addr), prev_addr);
            prev_stall = addr_valid && !ready;
            prev_addr  = int'(addr);
            if (done != '0) got = 1;
            else begin
                @(posedge clk); #1 ready = ~ready;
            end
        end
        chk("t4_got_done", int'(got), 1);
        chk("t4_done", int'(done), 2);
        chk("t4_wrap_addr", int'(addr), 0);
        chk("t4_xfers", xfer_cnt, MAXA + 1);
        @(posedge clk); #1 req = '0; ready = 1'b1;

        // owner drops req mid-sweep: sweep still completes
        push_sweep(3'b100, MAXA);
        @(posedge clk); #1 req = 3'b100;
        wait_addr(7, 40, "t5");
        @(posedge clk); #1 req = '0;
        wait_done(3'b100, 40, "t5");

`ifdef BIKE_SWEEP_ABORT_EN
        // abort of the owner ends the sweep early, pending requester follows
        push_sweep(3'b001, 4);
        push_sweep(3'b010, MAXA);
        @(posedge clk); #1 req = 3'b011;
        wait_addr(4, 40, "t6");
        @(posedge clk); #1 ready = 1'b0; abort_s = 3'b001;
        @(negedge clk);
        chk("t6_pre_addr", int'(addr), 5);
        @(negedge clk);
        chk("t6_valid", int'(addr_valid), 0);
        chk("t6_addr", int'(addr), 0);
        chk("t6_done", int'(done), 1);
        @(posedge clk); #1 abort_s = '0; ready = 1'b1; req = 3'b010;
        wait_done(3'b010, 40, "t6b");
        @(posedge clk); #1 req = '0;
`endif

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
